// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: datapath widths, ALU op
// encodings and the decoded-control bundle carried down the pipeline.
package mips_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned ALU_OP_W   = 4;
   localparam int unsigned CNT_W      = 32;

   // ALU operation encodings
   localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd0;
   localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd1;
   localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd2;
   localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd6;
   localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'd7;
   localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'd12;

   // Decoded control bundle
   typedef struct packed {
      logic                reg_write;
      logic                mem_read;
      logic                mem_write;
      logic                mem_to_reg;
      logic                alu_src;
      logic                reg_dst;
      logic [ALU_OP_W-1:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

   // Kill all control when the slot does not hold a real instruction
   function automatic ctrl_t ctrl_gate(input ctrl_t c, input logic valid);
      return valid ? c : CTRL_NOP;
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection.
// Ports:
//   ex_valid_i     EX holds a real instruction
//   ex_mem_read_i  EX instruction is a load
//   ex_wr_addr_i   EX destination register
//   id_valid_i     ID holds a real instruction
//   id_rs_i        ID source register A
//   id_rt_i        ID source register B
//   id_uses_rt_i   ID instruction reads rt as a source
//   load_use_o     ID depends on the load currently in EX
module load_use_detect
   import mips_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
   input  logic                  ex_valid_i,
   input  logic                  ex_mem_read_i,
   input  logic [REG_ADDR_W-1:0] ex_wr_addr_i,
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   input  logic                  id_uses_rt_i,
   output logic                  load_use_o
);

   logic load_in_ex;
   logic rs_match;
   logic rt_match;

   // A load to $0 never produces a value worth waiting for
   assign load_in_ex = ex_valid_i && ex_mem_read_i && id_valid_i
                       && (ex_wr_addr_i != '0);
   assign rs_match   = (id_rs_i == ex_wr_addr_i);
   assign rt_match   = id_uses_rt_i && (id_rt_i == ex_wr_addr_i);
   assign load_use_o = load_in_ex && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash,
// downstream hold and a count of inserted load-use bubbles.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   id_*                   decoded instruction from ID
//   ex_flush               squash the ID instruction (branch/jump taken)
//   ex_hold                freeze this stage
//   id_ex_*                registered operands/control presented to EX
//   id_ex_wr_addr          combinational destination select
//   pc_write, if_id_write  combinational upstream enables
//   stall_count            number of load-use bubbles inserted
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W     = mips_pkg::DATA_W,
   parameter int unsigned REG_ADDR_W = mips_pkg::REG_ADDR_W,
   parameter int unsigned ALU_OP_W   = mips_pkg::ALU_OP_W,
   parameter int unsigned CNT_W      = mips_pkg::CNT_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_uses_rt,
   input  logic [DATA_W-1:0]     id_reg_a_data,
   input  logic [DATA_W-1:0]     id_reg_b_data,
   input  logic [DATA_W-1:0]     id_imm,
   input  logic                  id_ctrl_reg_write,
   input  logic                  id_ctrl_mem_read,
   input  logic                  id_ctrl_mem_write,
   input  logic                  id_ctrl_mem_to_reg,
   input  logic                  id_ctrl_alu_src,
   input  logic                  id_ctrl_reg_dst,
   input  logic [ALU_OP_W-1:0]   id_ctrl_alu_op,
   input  logic                  ex_flush,
   input  logic                  ex_hold,
   output logic [REG_ADDR_W-1:0] id_ex_rs,
   output logic [REG_ADDR_W-1:0] id_ex_rt,
   output logic [REG_ADDR_W-1:0] id_ex_rd,
   output logic [DATA_W-1:0]     id_ex_reg_a_data,
   output logic [DATA_W-1:0]     id_ex_reg_b_data,
   output logic [DATA_W-1:0]     id_ex_imm,
   output logic                  id_ex_reg_write,
   output logic                  id_ex_mem_read,
   output logic                  id_ex_mem_write,
   output logic                  id_ex_mem_to_reg,
   output logic                  id_ex_alu_src,
   output logic [ALU_OP_W-1:0]   id_ex_alu_op,
   output logic [REG_ADDR_W-1:0] id_ex_wr_addr,
   output logic                  id_ex_valid,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic [CNT_W-1:0]      stall_count
);

   logic                  valid_q, valid_d;
   logic [REG_ADDR_W-1:0] rs_q, rs_d;
   logic [REG_ADDR_W-1:0] rt_q, rt_d;
   logic [REG_ADDR_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0]     a_q, a_d;
   logic [DATA_W-1:0]     b_q, b_d;
   logic [DATA_W-1:0]     imm_q, imm_d;
   ctrl_t                 ctrl_q, ctrl_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   ctrl_t                 id_ctrl;
   logic [REG_ADDR_W-1:0] wr_addr;
   logic                  load_use;
   logic                  stall;

   assign id_ctrl = '{reg_write:  id_ctrl_reg_write,
                      mem_read:   id_ctrl_mem_read,
                      mem_write:  id_ctrl_mem_write,
                      mem_to_reg: id_ctrl_mem_to_reg,
                      alu_src:    id_ctrl_alu_src,
                      reg_dst:    id_ctrl_reg_dst,
                      alu_op:     id_ctrl_alu_op};

   assign wr_addr = ctrl_q.reg_dst ? rd_q : rt_q;

   load_use_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_load_use_detect (
      .ex_valid_i    (valid_q),
      .ex_mem_read_i (ctrl_q.mem_read),
      .ex_wr_addr_i  (wr_addr),
      .id_valid_i    (id_valid),
      .id_rs_i       (id_rs),
      .id_rt_i       (id_rt),
      .id_uses_rt_i  (id_uses_rt),
      .load_use_o    (load_use)
   );

   // A flush or hold overrides the stall, so neither freezes the front end
   // on behalf of a load-use hazard
   assign stall       = load_use && !ex_flush && !ex_hold;
   assign pc_write    = !stall && !ex_hold;
   assign if_id_write = pc_write;

   // Next-state: flush > hold > stall > capture
   always_comb begin
      valid_d = valid_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      rd_d    = rd_q;
      a_d     = a_q;
      b_d     = b_q;
      imm_d   = imm_q;
      ctrl_d  = ctrl_q;
      cnt_d   = cnt_q;
      if (ex_flush && !ex_hold) begin
         valid_d = 1'b0;
         rs_d    = '0;
         rt_d    = '0;
         rd_d    = '0;
         a_d     = '0;
         b_d     = '0;
         imm_d   = '0;
         ctrl_d  = CTRL_NOP;
      end else if (ex_hold) begin
         valid_d = valid_q;
      end else if (stall) begin
         valid_d = 1'b0;
         rs_d    = '0;
         rt_d    = '0;
         rd_d    = '0;
         a_d     = '0;
         b_d     = '0;
         imm_d   = '0;
         ctrl_d  = CTRL_NOP;
         cnt_d   = cnt_q + CNT_W'(1);
      end else begin
         valid_d = id_valid;
         rs_d    = id_rs;
         rt_d    = id_rt;
         rd_d    = id_rd;
         a_d     = id_reg_a_data;
         b_d     = id_reg_b_data;
         imm_d   = id_imm;
         ctrl_d  = ctrl_gate(id_ctrl, id_valid);
      end
   end

   // Stage register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         ctrl_q  <= CTRL_NOP;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rd_q    <= rd_d;
         a_q     <= a_d;
         b_q     <= b_d;
         imm_q   <= imm_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
      end
   end

   assign id_ex_rs         = rs_q;
   assign id_ex_rt         = rt_q;
   assign id_ex_rd         = rd_q;
   assign id_ex_reg_a_data = a_q;
   assign id_ex_reg_b_data = b_q;
   assign id_ex_imm        = imm_q;
   assign id_ex_reg_write  = ctrl_q.reg_write;
   assign id_ex_mem_read   = ctrl_q.mem_read;
   assign id_ex_mem_write  = ctrl_q.mem_write;
   assign id_ex_mem_to_reg = ctrl_q.mem_to_reg;
   assign id_ex_alu_src    = ctrl_q.alu_src;
   assign id_ex_alu_op     = ctrl_q.alu_op;
   assign id_ex_wr_addr    = wr_addr;
   assign id_ex_valid      = valid_q;
   assign stall_count      = cnt_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core, with integrated load-use hazard detection.
- Captures decoded operands and control from ID and presents them to EX, including the rs/rt/data values that feed the ALU forwarding mux.
- Inserts a one-cycle bubble and freezes PC and IF/ID on a load-use dependency.
- Squashes the ID instruction on a branch/jump flush and keeps a stall-cycle counter.

Parameters:
- DATA_W, 32, register and immediate data width
- REG_ADDR_W, 5, register index width
- ALU_OP_W, 4, ALU operation code width
- CNT_W, 32, stall counter width

Ports:
- clk  input  1  clock, rising-edge
- rst_n  input  1  synchronous active-low reset
- id_valid  input  1  ID holds a real instruction
- id_rs  input  REG_ADDR_W  source register A index
- id_rt  input  REG_ADDR_W  source register B / load destination index
- id_rd  input  REG_ADDR_W  R-type destination index
- id_uses_rt  input  1  instruction reads rt as a source (R-type, store, branch)
- id_reg_a_data  input  DATA_W  register file read port A
- id_reg_b_data  input  DATA_W  register file read port B
- id_imm  input  DATA_W  sign-extended immediate
- id_ctrl_reg_write, id_ctrl_mem_read, id_ctrl_mem_write, id_ctrl_mem_to_reg, id_ctrl_alu_src, id_ctrl_reg_dst  input  1 each  decoded control
- id_ctrl_alu_op  input  ALU_OP_W  decoded ALU op
- ex_flush  input  1  branch/jump taken in EX; squash the ID instruction
- ex_hold  input  1  downstream hold; freeze this stage
- id_ex_rs, id_ex_rt, id_ex_rd  output  REG_ADDR_W  registered indices (to forwarding unit)
- id_ex_reg_a_data, id_ex_reg_b_data, id_ex_imm  output  DATA_W  registered operands
- id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_alu_src  output  1 each  registered control
- id_ex_alu_op  output  ALU_OP_W  registered ALU op
- id_ex_wr_addr  output  REG_ADDR_W  combinational: reg_dst_q ? rd_q : rt_q
- id_ex_valid  output  1  EX holds a real instruction
- pc_write  output  1  PC update enable
- if_id_write  output  1  IF/ID register enable
- stall_count  output  CNT_W  count of load-use bubbles inserted

Behaviour:
- Reset (rst_n=0 at a clk edge): every registered output is 0, including id_ex_valid and stall_count.
  - pc_write=1 and if_id_write=1 while in reset, because both are combinational from cleared state.
- load_use is combinational. It is 1 when all of the following hold:
  - id_ex_valid && id_ex_mem_read && id_valid && id_ex_wr_addr!=0
  - and either (id_rs==id_ex_wr_addr) or (id_uses_rt && id_rt==id_ex_wr_addr)
- stall = load_use && !ex_flush && !ex_hold.
- pc_write = !stall && !ex_hold. if_id_write equals pc_write.
- Register update priority, evaluated each rising edge with rst_n=1 (first match wins):
  1. ex_flush=1 and ex_hold=0: load a bubble. All control bits, alu_op and valid are cleared; indices and data are don't-care, but the implementation clears them to 0. The flush wins over a simultaneous load_use.
  2. ex_hold=1: all registers keep their value. A simultaneous ex_flush is ignored this cycle; the upstream asserting it must hold it until ex_hold drops. stall_count is unchanged.
  3. stall=1: load a bubble and increment stall_count by 1. The counter wraps modulo 2^CNT_W.
  4. Otherwise: capture all id_* inputs. id_ex_valid takes id_valid, and control bits are ANDed with id_valid.
- Latency: one cycle from ID inputs to id_ex_* outputs.
- A load followed by a dependent instruction yields exactly one bubble. On the next cycle id_ex_mem_read=0, so load_use clears and the dependent instruction is captured. Its operand then comes from the MEM/WB forwarding path.
- A $0 destination never triggers a stall.
- A store whose only dependency is via rt still stalls when id_uses_rt=1; there is no MEM-stage store-data forwarding.
- Reset mid-stall takes effect on the next edge, and the pipeline resumes from the captured state.

Decomposition:
- Shared package (mips_pkg): DATA_W, REG_ADDR_W, ALU_OP_W, ALU op encodings, and a ctrl bundle typedef (reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op).
- One natural sub-module: load_use_detect, which is purely combinational and produces load_use. The register and counter stay in id_ex_stage.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with inputs toggling -> all id_ex_* = 0, stall_count=0, pc_write=1.
- Pass-through: id_valid=1, rs=3, rt=4, rd=5, reg_write=1, alu_op=2, reg_a=0x11, reg_b=0x22 -> next cycle id_ex_rs=3, id_ex_rt=4, id_ex_wr_addr=5 (reg_dst=1), id_ex_reg_a_data=0x11, id_ex_alu_op=2.
- Load-use: EX holds lw with rt=8; ID holds add with rs=8 -> stall cycle has pc_write=0 and if_id_write=0. Next cycle has a bubble (id_ex_valid=0, mem_read=0) and stall_count=1. The cycle after captures the add with rs=8.
- No stall cases: lw with rt=0, or ID reading rt=8 with id_uses_rt=0 -> pc_write=1 and no bubble.
- Flush beats stall: load_use conditions true and ex_flush=1 -> bubble loaded, pc_write=1, stall_count unchanged.
- Hold: ex_hold=1 for 3 cycles with changing ID inputs and a load_use condition -> outputs frozen, pc_write=0, stall_count unchanged. After release, the stall proceeds normally.
